mux_4_1_rr_arbiter: RTL and testbench
=====================================

// Module: mux_4_1_rr_arbiter
// PURPOSE
//  Shares one W-bit 4:1 mux output channel between four valid/ready requesters.
//  Round-robin (or fixed-priority) arbiter chooses the mux select. The chosen
//  word is captured in an output register with a valid/ready handshake toward
//  the consumer. Sits between up to four producers and a single downstream sink.
// PARAMETERS
//  W           4   data width of every requester and of the output
//  ROUND_ROBIN 1   1: rotating priority; 0: fixed priority, req 0 highest
// PORTS
//  clk        input   1    clock, all state on rising edge
//  rst        input   1    reset, synchronous, active-low (0 = reset)
//  in_valid   input   4    in_valid[i]: requester i offers in_data[i]
//  in_data    input   4xW  unpacked [0:3] array of W-bit words
//  in_ready   output  4    one-hot or zero; transfer i when in_valid[i]&in_ready[i]
//  out_valid  output  1    out_data/out_sel hold a word
//  out_ready  input   1    consumer accepts when out_valid&out_ready
//  out_data   output  W    registered word from the granted requester
//  out_sel    output  2    index of the requester that supplied out_data
// BEHAVIOUR
//  - Reset (rst==0 at edge): out_valid=0, out_data=0, out_sel=0, ptr=0.
//    in_ready=0 while rst==0 (combinational gate). Word in flight is dropped.
//  - load = !out_valid | out_ready (output empty or draining this cycle).
//  - Grant search, combinational: order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
//    Pick the first i with in_valid[i]. If ROUND_ROBIN=0, ptr is treated as 0.
//  - in_ready[g] = load & rst & any_valid. Exactly one bit is set; all others 0.
//    in_ready may depend on in_valid. out_valid never depends on out_ready.
//  - On an edge with load & any_valid:
//    out_data<=in_data[g], out_sel<=g, out_valid<=1.
//    If ROUND_ROBIN, ptr<=g+1 mod 4 (3 wraps to 0).
//  - On an edge with load & !any_valid: out_valid<=0.
//    out_data/out_sel and ptr hold.
//  - Stall (out_valid & !out_ready): out_*, ptr hold. in_ready=0.
//  - Latency: input accept to out_valid is 1 cycle.
//    Throughput: 1 word/cycle while out_ready=1.
//  - Simultaneous drain and refill (out_valid & out_ready & any_valid):
//    new word loads same edge, out_valid stays 1, no bubble.
//  - Fairness (ROUND_ROBIN=1): a requester holding in_valid waits at most
//    3 other transfers before it is granted.
//  - Requesters keep in_valid/in_data stable until accepted. The block does not
//    check this. A dropped in_valid before accept is legal and simply not granted.
// STRUCTURE
//  - Package mux_arb_pkg: localparam int N_REQ=4; typedef logic [1:0] sel_t.
//  - Sub-module rr_pick_4: combinational.
//    Inputs: req[3:0], ptr sel_t.
//    Outputs: gnt_idx sel_t, gnt_any.
//  - Top holds ptr and the output register, gates in_ready, and muxes in_data by
//    gnt_idx using the ?: select chain.
//  - No other state. Target 120-200 lines total.
// TESTING
//  1. Reset: hold rst=0 with in_valid=4'hF.
//     -> in_ready=0, out_valid=0, out_sel=0. After release, first grant is req 0.
//  2. Rotation: in_valid=4'hF constant, in_data={A,B,C,D}, out_ready=1.
//     -> out_sel 0,1,2,3,0 on consecutive cycles; out_data A,B,C,D,A.
//  3. Stall: out_valid=1, out_sel=2, out_ready=0 for 3 cycles.
//     -> out_data/out_sel stable, in_ready=0. Release -> next grant is req 3.
//  4. Sparse: only in_valid[1] pulsed one cycle, data 4'h9.
//     -> next cycle out_valid=1, out_sel=1, out_data=9.
//     Following idle cycle with out_ready=1 -> out_valid=0.
//  5. Wrap and skip: ptr=3, in_valid=4'b0010.
//     -> grant req 1, ptr becomes 2. Then in_valid=4'b0001 -> grant req 0.
//  6. ROUND_ROBIN=0, in_valid=4'b1010, out_ready=1 for 4 cycles.
//     -> out_sel=1 every cycle, req 3 never granted.
//     Mid-stream rst=0 one cycle -> out_valid=0 next cycle.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types for the 4-requester output-channel arbiter.
package mux_arb_pkg;
  localparam int N_REQ = 4;
  typedef logic [1:0] sel_t;
endpackage

// File: rtl/rr_pick_4.sv
// Combinational rotating-priority pick: first requester at or after ptr wins.
module rr_pick_4
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  sel_t             ptr,
  output sel_t             gnt_idx,
  output logic             gnt_any
);

  always_comb begin
    sel_t cand;
    gnt_idx = '0;
    gnt_any = 1'b0;
    // Walk offsets from farthest to nearest so the nearest valid one is kept.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + sel_t'(k);
      if (req[cand]) begin
        gnt_idx = cand;
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_4_1_rr_arbiter.sv
// Four valid/ready requesters share one registered output word; a rotating
// (or fixed) priority pick drives the 4:1 data select.
module mux_4_1_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int W           = 4,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] in_valid,
  input  logic [W-1:0]     in_data [0:N_REQ-1],
  output logic [N_REQ-1:0] in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output sel_t             out_sel
);

  sel_t         ptr_p1;
  sel_t         pick_ptr;
  sel_t         gnt_idx;
  logic         gnt_any;
  logic         load;
  logic [W-1:0] data_p0;
  logic [W-1:0] data_p1;
  sel_t         sel_p1;
  logic         vld_p1;

  assign load     = !vld_p1 || out_ready;
  assign pick_ptr = ROUND_ROBIN ? ptr_p1 : sel_t'(0);

  rr_pick_4 u_pick (
    .req     (in_valid),
    .ptr     (pick_ptr),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign in_ready = (load && rst && gnt_any) ? ((N_REQ)'(1'b1) << gnt_idx) : '0;

  assign data_p0 = (gnt_idx == 2'd0) ? in_data[0] :
                   (gnt_idx == 2'd1) ? in_data[1] :
                   (gnt_idx == 2'd2) ? in_data[2] : in_data[3];

  // p0 -> p1: capture the granted word when the output slot is free or draining.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      sel_p1  <= '0;
      ptr_p1  <= '0;
    end else if (load) begin
      if (gnt_any) begin
        vld_p1  <= 1'b1;
        data_p1 <= data_p0;
        sel_p1  <= gnt_idx;
        if (ROUND_ROBIN) ptr_p1 <= gnt_idx + sel_t'(1);
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_sel   = sel_p1;

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Bench for mux_4_1_rr_arbiter: rotating instance (a) and fixed-priority instance (b).
module tb_mux_4_1_rr_arbiter;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] data;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] in_valid;
  logic [3:0] in_data [0:3];
  logic       out_ready;

  logic [3:0] rdy_a, rdy_b;
  logic       ov_a, ov_b;
  logic [3:0] od_a, od_b;
  logic [1:0] os_a, os_b;

  exp_t       q_a[$];
  exp_t       q_b[$];
  logic [1:0] ptr_a;
  logic [3:0] exp_rdy_a, exp_rdy_b, obs_rdy_a, obs_rdy_b;
  logic [3:0] lane [0:3];

  int checks = 0;
  int errors = 0;

  mux_4_1_rr_arbiter #(.W(4), .ROUND_ROBIN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_a), .out_valid(ov_a), .out_ready(out_ready),
    .out_data(od_a), .out_sel(os_a)
  );

  mux_4_1_rr_arbiter #(.W(4), .ROUND_ROBIN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_b), .out_valid(ov_b), .out_ready(out_ready),
    .out_data(od_b), .out_sel(os_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference pick: rotate the request vector by p, take lowest set bit.
  function automatic logic [1:0] m_pick(input logic [3:0] v, input logic [1:0] p);
    logic [7:0] dbl;
    logic [3:0] rot;
    dbl = {v, v};
    rot = 4'(dbl >> p);
    m_pick = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (rot[k]) begin
        m_pick = 2'((int'(p) + k) % 4);
        break;
      end
    end
  endfunction

  // Advance one clock; predicts in_ready before the edge and updates the scoreboard.
  task automatic tick();
    logic       any, la, lb;
    logic [1:0] ga, gb;
    #2;
    any = |in_valid;
    la  = (q_a.size() == 0) || out_ready;
    lb  = (q_b.size() == 0) || out_ready;
    ga  = m_pick(in_valid, ptr_a);
    gb  = m_pick(in_valid, 2'd0);
    exp_rdy_a = (rst && la && any) ? (4'b0001 << ga) : 4'b0000;
    exp_rdy_b = (rst && lb && any) ? (4'b0001 << gb) : 4'b0000;
    obs_rdy_a = rdy_a;
    obs_rdy_b = rdy_b;
    @(posedge clk);
    if (!rst) begin
      q_a.delete();
      q_b.delete();
      ptr_a = 2'd0;
    end else begin
      if (q_a.size() != 0 && out_ready) void'(q_a.pop_front());
      if (q_b.size() != 0 && out_ready) void'(q_b.pop_front());
      if (la && any) begin
        q_a.push_back('{sel: ga, data: in_data[ga]});
        ptr_a = ga + 2'd1;
      end
      if (lb && any) q_b.push_back('{sel: gb, data: in_data[gb]});
    end
    #1;
  endtask

  task automatic set_lanes();
    for (int i = 0; i < 4; i++) in_data[i] = lane[i];
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
    set_lanes();
    tick(); tick();
    checks++; if (obs_rdy_a !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b want 0000", obs_rdy_a); end
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ov_a); end
    checks++; if (os_a !== 2'd0) begin errors++; $display("FAIL reset_out_sel got %0d want 0", os_a); end
    checks++; if (od_a !== 4'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", od_a); end
    checks++; if (ov_b !== 1'b0) begin errors++; $display("FAIL reset_out_valid_fp got %b want 0", ov_b); end
    rst = 1'b1;
    tick();
    checks++; if (obs_rdy_a !== 4'b0001) begin errors++; $display("FAIL first_grant_ready got %b want 0001", obs_rdy_a); end
    checks++; if (ov_a !== 1'b1 || os_a !== 2'd0) begin errors++; $display("FAIL first_grant got v%b sel%0d want v1 sel0", ov_a, os_a); end
  endtask

  task automatic test_rotation();
    rst = 1'b0; tick(); rst = 1'b1;
    in_valid = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (obs_rdy_a !== exp_rdy_a) begin errors++; $display("FAIL rot_ready[%0d] got %b want %b", i, obs_rdy_a, exp_rdy_a); end
      checks++; if (ov_a !== 1'b1 || os_a !== 2'(i % 4) || od_a !== lane[i % 4])
        begin errors++; $display("FAIL rot_out[%0d] got v%b sel%0d data%h want v1 sel%0d data%h", i, ov_a, os_a, od_a, i % 4, lane[i % 4]); end
    end
  endtask

  task automatic test_stall();
    in_valid = 4'b0100; out_ready = 1'b1;
    tick();
    checks++; if (os_a !== 2'd2 || od_a !== lane[2]) begin errors++; $display("FAIL stall_setup got sel%0d data%h want sel2 data%h", os_a, od_a, lane[2]); end
    in_valid = 4'hF; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (obs_rdy_a !== 4'b0000) begin errors++; $display("FAIL stall_ready[%0d] got %b want 0000", i, obs_rdy_a); end
      checks++; if (ov_a !== 1'b1 || os_a !== 2'd2 || od_a !== lane[2])
        begin errors++; $display("FAIL stall_hold[%0d] got v%b sel%0d data%h want v1 sel2 data%h", i, ov_a, os_a, od_a, lane[2]); end
    end
    out_ready = 1'b1;
    tick();
    checks++; if (obs_rdy_a !== 4'b1000) begin errors++; $display("FAIL stall_release_ready got %b want 1000", obs_rdy_a); end
    checks++; if (os_a !== 2'd3 || od_a !== lane[3]) begin errors++; $display("FAIL stall_release got sel%0d data%h want sel3 data%h", os_a, od_a, lane[3]); end
  endtask

  task automatic test_sparse();
    out_ready = 1'b1; in_valid = 4'b0010; in_data[1] = 4'h9;
    tick();
    checks++; if (ov_a !== 1'b1 || os_a !== 2'd1 || od_a !== 4'h9)
      begin errors++; $display("FAIL sparse_out got v%b sel%0d data%h want v1 sel1 data9", ov_a, os_a, od_a); end
    in_valid = 4'b0000;
    tick();
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL sparse_idle got v%b want v0", ov_a); end
    set_lanes();
  endtask

  task automatic test_wrap_skip();
    logic [3:0] vecs [0:3];
    logic [1:0] want [0:3];
    vecs = '{4'b0100, 4'b0010, 4'b0001, 4'b1001};
    want = '{2'd2, 2'd1, 2'd0, 2'd3};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = vecs[i];
      tick();
      checks++; if (ov_a !== 1'b1 || os_a !== want[i] || od_a !== lane[want[i]])
        begin errors++; $display("FAIL wrap_skip[%0d] got v%b sel%0d data%h want v1 sel%0d", i, ov_a, os_a, od_a, want[i]); end
    end
  endtask

  task automatic test_fixed_priority();
    rst = 1'b0; tick(); rst = 1'b1;
    in_valid = 4'b1010; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (obs_rdy_b !== 4'b0010) begin errors++; $display("FAIL fp_ready[%0d] got %b want 0010", i, obs_rdy_b); end
      checks++; if (ov_b !== 1'b1 || os_b !== 2'd1 || od_b !== lane[1])
        begin errors++; $display("FAIL fp_out[%0d] got v%b sel%0d data%h want v1 sel1", i, ov_b, os_b, od_b); end
    end
    rst = 1'b0;
    tick();
    checks++; if (ov_b !== 1'b0 || ov_a !== 1'b0) begin errors++; $display("FAIL fp_midreset got va%b vb%b want 0 0", ov_a, ov_b); end
    rst = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < 4; j++) in_data[j] = 4'($urandom_range(0, 15));
      tick();
      checks++; if (obs_rdy_a !== exp_rdy_a) begin errors++; $display("FAIL rnd_ready_a[%0d] got %b want %b", i, obs_rdy_a, exp_rdy_a); end
      checks++; if (obs_rdy_b !== exp_rdy_b) begin errors++; $display("FAIL rnd_ready_b[%0d] got %b want %b", i, obs_rdy_b, exp_rdy_b); end
      checks++; if (ov_a !== (q_a.size() != 0)) begin errors++; $display("FAIL rnd_valid_a[%0d] got %b want %b", i, ov_a, q_a.size() != 0); end
      checks++; if (ov_b !== (q_b.size() != 0)) begin errors++; $display("FAIL rnd_valid_b[%0d] got %b want %b", i, ov_b, q_b.size() != 0); end
      if (q_a.size() != 0) begin
        checks++; if (os_a !== q_a[0].sel || od_a !== q_a[0].data)
          begin errors++; $display("FAIL rnd_word_a[%0d] got sel%0d data%h want sel%0d data%h", i, os_a, od_a, q_a[0].sel, q_a[0].data); end
      end
      if (q_b.size() != 0) begin
        checks++; if (os_b !== q_b[0].sel || od_b !== q_b[0].data)
          begin errors++; $display("FAIL rnd_word_b[%0d] got sel%0d data%h want sel%0d data%h", i, os_b, od_b, q_b[0].sel, q_b[0].data); end
      end
    end
  endtask

  initial begin
    lane      = '{4'hA, 4'hB, 4'hC, 4'hD};
    ptr_a     = 2'd0;
    rst       = 1'b0;
    in_valid  = 4'h0;
    out_ready = 1'b0;
    set_lanes();
    test_reset();
    test_rotation();
    test_stall();
    test_sparse();
    test_wrap_skip();
    test_fixed_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
